scl_phase_generator: RTL
========================

# scl_phase_generator

Parametrised, runtime-programmable successor to the I2C baud clock divider. Produces a 50 % duty SCL-style clock split into four equal quarter-phases, one-cycle strobes at the data-change and data-sample points, glitch-free divisor updates at period boundaries, and optional slave clock-stretch detection. Sits between the I2C master FSM (consumes strobes, drives EN) and the open-drain SCL pad (drives CLK_OUT, senses SCL_IN).

## Interface
- CNT_W, 16, width of divisor and quarter counter
- DEFAULT_DIV, 16'd124, divisor loaded at reset (quarter length = DIV+1 cycles)
- CLK  input  1  clock
- RESET  input  1  reset RESET, synchronous, active-high; clock CLK
- EN  input  1  run request; low = idle
- DIV  input  CNT_W  new quarter divisor
- DIV_LD  input  1  one-cycle strobe capturing DIV into pending register
- SCL_IN  input  1  sensed SCL line, asynchronous
- CLK_OUT  output  1  generated clock, high when idle
- PHASE  output  2  current quarter: 0 = low-first, 1 = low-second, 2 = high-first, 3 = high-second
- TICK_PERIOD  output  1  pulse on first cycle of Q0
- TICK_LOW_MID  output  1  pulse on first cycle of Q1 (SDA change point)
- TICK_HIGH_MID  output  1  pulse on first cycle of Q3 (SDA sample point)
- STRETCH  output  1  high while Q2 is held by low SCL_IN
- BUSY  output  1  high whenever not idle

## Operation
- Registers: cnt[CNT_W-1:0], phase[1:0], active_div, pending_div, busy, 2-flop SCL_IN synchroniser (scl_s).
- RESET (highest priority): cnt=0, PHASE=3, CLK_OUT=1, all ticks=0, STRETCH=0, BUSY=0, active_div=pending_div=DEFAULT_DIV, synchroniser=1.
- DIV_LD: pending_div<=DIV. Accepted in any state, including idle.
- Idle, EN=1: next edge enters Q0, cnt=0, CLK_OUT=0, TICK_PERIOD=1, active_div<=(DIV_LD ? DIV : pending_div).
- Running: cnt increments; when cnt==active_div, cnt<=0 and phase advances 0→1→2→3→0. CLK_OUT=phase[1].
- Q3→Q0 wrap loads active_div exactly as idle entry (same-edge DIV_LD bypasses pending). Divisor never changes mid-period.
- EN deasserted while running: next edge returns to idle (CLK_OUT=1, PHASE=3, cnt=0), no period completion. Same edge DIV_LD still updates pending_div.
- Ticks are one-cycle registered pulses, asserted in the first cycle of the named phase only. They never assert in idle.
- Equality compare only; cnt never exceeds active_div. DIV=0 is legal: 4-cycle period, every quarter 1 cycle.

## Timing
- Latency EN→CLK_OUT low: 1 cycle.
- Unstretched period: 4*(DIV+1) cycles. Low time = high time = 2*(DIV+1).
- TICK_LOW_MID is DIV+1 cycles after TICK_PERIOD. TICK_HIGH_MID is 3*(DIV+1) cycles after TICK_PERIOD (unstretched).
- Divisor update latency: effective at the next Q0 entry after DIV_LD, or at that entry if on the same edge.
- Back-to-back periods have no idle gap; TICK_PERIOD repeats every period.

## Configuration
- SCL_STRETCH_EN defined: in Q2, cnt holds at 0 and STRETCH=1 while scl_s==0. Counting resumes on the first cycle scl_s==1. With SCL_IN looped to CLK_OUT, synchroniser lag makes Q2 last DIV+3 cycles. EN drop or RESET aborts a stretch immediately.
- Not defined: SCL_IN and synchroniser ignored, STRETCH tied 0, Q2 always DIV+1 cycles.

## Test plan
- Reset default: RESET 1 cycle, EN=1 -> CLK_OUT period 500 cycles, low 250, TICK_LOW_MID 125 cycles after TICK_PERIOD, TICK_HIGH_MID 375 after.
- DIV=0 via DIV_LD, EN=1 -> PHASE 0,1,2,3 each 1 cycle, CLK_OUT 0011 repeating, all ticks once per 4 cycles.
- DIV_LD DIV=3 mid-Q1 of a DIV=9 period -> current period stays 40 cycles, next period 16. DIV_LD coincident with Q3→Q0 wrap -> new value used immediately.
- EN dropped in Q2 cycle 5 (DIV=9) -> next cycle CLK_OUT=1, PHASE=3, BUSY=0, no further ticks. Re-assert -> fresh Q0 with TICK_PERIOD.
- SCL_STRETCH_EN, DIV=4, SCL_IN held low 20 cycles after Q2 entry -> STRETCH=1 for those 20 cycles plus 2 synchroniser cycles, TICK_HIGH_MID 5 cycles after SCL_IN release is synchronised. Without macro -> no stretch, STRETCH=0.
- RESET asserted mid-Q1 with pending DIV=7 -> all outputs to reset values next cycle, next run uses DEFAULT_DIV.

Source files
------------

// File: rtl/scl_phase_generator.sv
// Four-quarter SCL phase generator with strobes and glitch-free runtime divisor reload.
// Define SCL_STRETCH_EN to hold Q2 while the synchronised SCL_IN is low (slave clock stretching).
module scl_phase_generator #(
    parameter int unsigned        CNT_W       = 16,
    parameter logic [CNT_W-1:0]   DEFAULT_DIV = CNT_W'(124)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic [CNT_W-1:0] DIV,
    input  logic             DIV_LD,
    input  logic             SCL_IN,
    output logic             CLK_OUT,
    output logic [1:0]       PHASE,
    output logic             TICK_PERIOD,
    output logic             TICK_LOW_MID,
    output logic             TICK_HIGH_MID,
    output logic             STRETCH,
    output logic             BUSY
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] active_div_q, active_div_d;
    logic [CNT_W-1:0] pending_div_q, pending_div_d;
    logic [CNT_W-1:0] next_div;
    logic [1:0]       phase_q, phase_d, phase_inc;
    logic             clk_out_q, clk_out_d;
    logic             tick_period_q, tick_period_d;
    logic             tick_low_mid_q, tick_low_mid_d;
    logic             tick_high_mid_q, tick_high_mid_d;
    logic             hold;

`ifdef SCL_STRETCH_EN
    logic scl_meta_q, scl_sync_q;
    logic stretch_q, stretch_d;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            stretch_q  <= 1'b0;
        end else begin
            scl_meta_q <= SCL_IN;
            scl_sync_q <= scl_meta_q;
            stretch_q  <= stretch_d;
        end
    end

    // Stretch only at the start of Q2: the counter is parked at zero until SCL is seen high.
    assign hold = (phase_q == 2'd2) && (cnt_q == '0) && !scl_sync_q;

    // Registered flag mirrors hold for the coming cycle; scl_meta_q is next cycle's scl_s.
    always_comb begin
        stretch_d = (state_d == StRun) && (phase_d == 2'd2) && (cnt_d == '0) && !scl_meta_q;
    end

    assign STRETCH = stretch_q;
`else
    logic unused_scl;
    assign unused_scl = SCL_IN;
    assign hold       = 1'b0;
    assign STRETCH    = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            phase_q         <= 2'd3;
            active_div_q    <= DEFAULT_DIV;
            pending_div_q   <= DEFAULT_DIV;
            clk_out_q       <= 1'b1;
            tick_period_q   <= 1'b0;
            tick_low_mid_q  <= 1'b0;
            tick_high_mid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            phase_q         <= phase_d;
            active_div_q    <= active_div_d;
            pending_div_q   <= pending_div_d;
            clk_out_q       <= clk_out_d;
            tick_period_q   <= tick_period_d;
            tick_low_mid_q  <= tick_low_mid_d;
            tick_high_mid_q <= tick_high_mid_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        phase_d         = phase_q;
        active_div_d    = active_div_q;
        clk_out_d       = clk_out_q;
        tick_period_d   = 1'b0;
        tick_low_mid_d  = 1'b0;
        tick_high_mid_d = 1'b0;
        phase_inc       = phase_q + 2'd1;

        // A same-edge load bypasses the pending register so it takes effect at this Q0 entry.
        next_div      = DIV_LD ? DIV : pending_div_q;
        pending_div_d = next_div;

        case (state_q)
            StIdle: begin
                cnt_d     = '0;
                phase_d   = 2'd3;
                clk_out_d = 1'b1;
                if (EN) begin
                    state_d       = StRun;
                    phase_d       = 2'd0;
                    clk_out_d     = 1'b0;
                    tick_period_d = 1'b1;
                    active_div_d  = next_div;
                end
            end
            StRun: begin
                if (!EN) begin
                    state_d   = StIdle;
                    cnt_d     = '0;
                    phase_d   = 2'd3;
                    clk_out_d = 1'b1;
                end else if (hold) begin
                    cnt_d = '0;
                end else if (cnt_q == active_div_q) begin
                    cnt_d           = '0;
                    phase_d         = phase_inc;
                    clk_out_d       = phase_inc[1];
                    tick_period_d   = (phase_q == 2'd3);
                    tick_low_mid_d  = (phase_q == 2'd0);
                    tick_high_mid_d = (phase_q == 2'd2);
                    if (phase_q == 2'd3) begin
                        active_div_d = next_div;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = StIdle;
                cnt_d     = '0;
                phase_d   = 2'd3;
                clk_out_d = 1'b1;
            end
        endcase
    end

    assign CLK_OUT       = clk_out_q;
    assign PHASE         = phase_q;
    assign TICK_PERIOD   = tick_period_q;
    assign TICK_LOW_MID  = tick_low_mid_q;
    assign TICK_HIGH_MID = tick_high_mid_q;
    assign BUSY          = (state_q == StRun);

endmodule
